// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample type, state enum and bit-reverse helper
// for the 32-point FFT front end.
package fft_pkg;
    localparam int N_POINTS = 32;
    localparam int LOG2N    = 5;
    localparam int BITS     = 16;

    typedef logic [2*BITS-1:0] cplx_t;

    typedef enum logic {FILL, FULL} state_t;

    function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: 32 sample slot registers with a single write port,
// all slots exposed in parallel as one flat vector (slot i at [i*W +: W]).
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [LOG2N-1:0]      waddr,
    input  logic [W-1:0]          wdata,
    output logic [N_POINTS*W-1:0] slots
);
    logic [W-1:0] slot_q [N_POINTS];
    logic [W-1:0] slot_d [N_POINTS];

    always_comb begin
        for (int i = 0; i < N_POINTS; i++)
            slot_d[i] = (we && waddr == LOG2N'(i)) ? wdata : slot_q[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_POINTS; i++) slot_q[i] <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    for (genvar g = 0; g < N_POINTS; g++) begin : g_slot
        assign slots[g*W +: W] = slot_q[g];
    end
endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: serial-to-parallel loader placing sample k at slot bitrev5(k).
// Define FFT_LOADER_PINGPONG_EN for a two-bank build that fills while presenting.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int fix_bit = 7,
    parameter int bits    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2*bits-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic              frame_ack,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [2*bits-1:0] out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
    output logic [2*bits-1:0] out8,  out9,  out10, out11, out12, out13, out14, out15,
    output logic [2*bits-1:0] out16, out17, out18, out19, out20, out21, out22, out23,
    output logic [2*bits-1:0] out24, out25, out26, out27, out28, out29, out30, out31
);
    // fix_bit only travels with the datapath; samples pass through bit-exact
    localparam int W = 2 * bits + 0 * fix_bit;

    logic [LOG2N-1:0]      count_q, count_d;
    logic                  err_q, err_d;
    logic                  fire, last_slot;
    logic [N_POINTS*W-1:0] pres, slots0;

    assign fire      = s_valid && s_ready;
    assign last_slot = count_q == LOG2N'(N_POINTS - 1);
    assign frame_err = err_q;

    always_comb begin
        err_d   = fire && (last_slot ? !s_last : s_last);
        count_d = !fire ? count_q : (last_slot || s_last) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

`ifdef FFT_LOADER_PINGPONG_EN
    logic [1:0]            full_q, full_d;
    logic                  wb_q, wb_d, pb_q, pb_d, done, ack;
    logic [N_POINTS*W-1:0] slots1;

    // wb_q: bank being filled, pb_q: bank being presented (oldest full one)
    assign s_ready     = reset && !full_q[wb_q];
    assign frame_valid = full_q[pb_q];
    assign pres        = pb_q ? slots1 : slots0;

    always_comb begin
        done   = fire && last_slot;
        ack    = frame_ack && full_q[pb_q];
        full_d = full_q;
        if (done) full_d[wb_q] = 1'b1;
        if (ack) full_d[pb_q] = 1'b0;
        wb_d = wb_q ^ done;
        pb_d = pb_q ^ ack;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= '0;
            wb_q   <= 1'b0;
            pb_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            pb_q   <= pb_d;
        end
    end

    fft_frame_bank #(.W(W)) u_bank1 (
        .clk(clk), .reset(reset), .we(fire && wb_q), .waddr(bitrev5(count_q)),
        .wdata(s_data), .slots(slots1)
    );
    fft_frame_bank #(.W(W)) u_bank0 (
        .clk(clk), .reset(reset), .we(fire && !wb_q), .waddr(bitrev5(count_q)),
        .wdata(s_data), .slots(slots0)
    );
`else
    state_t state_q, state_d;

    assign s_ready     = reset && state_q == FILL;
    assign frame_valid = state_q == FULL;
    assign pres        = slots0;

    always_comb begin
        state_d = state_q == FILL ? (fire && last_slot ? FULL : FILL) : (frame_ack ? FILL : FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FILL;
        else state_q <= state_d;
    end

    fft_frame_bank #(.W(W)) u_bank0 (
        .clk(clk), .reset(reset), .we(fire), .waddr(bitrev5(count_q)),
        .wdata(s_data), .slots(slots0)
    );
`endif

    assign out0  = pres[0*W +: W];   assign out1  = pres[1*W +: W];
    assign out2  = pres[2*W +: W];   assign out3  = pres[3*W +: W];
    assign out4  = pres[4*W +: W];   assign out5  = pres[5*W +: W];
    assign out6  = pres[6*W +: W];   assign out7  = pres[7*W +: W];
    assign out8  = pres[8*W +: W];   assign out9  = pres[9*W +: W];
    assign out10 = pres[10*W +: W];  assign out11 = pres[11*W +: W];
    assign out12 = pres[12*W +: W];  assign out13 = pres[13*W +: W];
    assign out14 = pres[14*W +: W];  assign out15 = pres[15*W +: W];
    assign out16 = pres[16*W +: W];  assign out17 = pres[17*W +: W];
    assign out18 = pres[18*W +: W];  assign out19 = pres[19*W +: W];
    assign out20 = pres[20*W +: W];  assign out21 = pres[21*W +: W];
    assign out22 = pres[22*W +: W];  assign out23 = pres[23*W +: W];
    assign out24 = pres[24*W +: W];  assign out25 = pres[25*W +: W];
    assign out26 = pres[26*W +: W];  assign out27 = pres[27*W +: W];
    assign out28 = pres[28*W +: W];  assign out29 = pres[29*W +: W];
    assign out30 = pres[30*W +: W];  assign out31 = pres[31*W +: W];
endmodule
